// File: rtl/stream_demultiplexer_if.sv
// stream_demultiplexer_if: valid/ready input stream, four registered output channels and per-channel accept counters
interface stream_demultiplexer_if #(
  parameter int WIDTH = 8,
  parameter int COUNT_WIDTH = 8
);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic address0;
  logic address1;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [WIDTH-1:0] out0_data;
  logic [WIDTH-1:0] out1_data;
  logic [WIDTH-1:0] out2_data;
  logic [WIDTH-1:0] out3_data;
  logic [COUNT_WIDTH-1:0] count0;
  logic [COUNT_WIDTH-1:0] count1;
  logic [COUNT_WIDTH-1:0] count2;
  logic [COUNT_WIDTH-1:0] count3;
  modport master (
    output in_valid, in_data, address0, address1, out_ready,
    input in_ready, out_valid, out0_data, out1_data, out2_data, out3_data,
    input count0, count1, count2, count3
  );
  modport slave (
    input in_valid, in_data, address0, address1, out_ready,
    output in_ready, out_valid, out0_data, out1_data, out2_data, out3_data,
    output count0, count1, count2, count3
  );
endinterface

// File: rtl/stream_demultiplexer.sv
// stream_demultiplexer: routes each input word to one of four one-entry output registers by {address1, address0}
module stream_demultiplexer #(
  parameter int WIDTH = 8,
  parameter int COUNT_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  stream_demultiplexer_if.slave bus
);
  logic [1:0] sel;
  logic accept;
  logic [3:0] valid_q;
  logic [WIDTH-1:0] data_q [4];
  logic [COUNT_WIDTH-1:0] cnt_q [4];
  assign sel = {bus.address1, bus.address0};
  assign bus.in_ready = !reset && (!valid_q[sel] || bus.out_ready[sel]);
  assign accept = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk)
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else
      for (int k = 0; k < 4; k++)
        if (accept && sel == 2'(k)) begin
          data_q[k] <= bus.in_data;
          valid_q[k] <= 1'b1;
          cnt_q[k] <= cnt_q[k] + COUNT_WIDTH'(1);
        end else if (bus.out_ready[k])
          valid_q[k] <= 1'b0;
  assign bus.out_valid = valid_q;
  assign bus.out0_data = data_q[0];
  assign bus.out1_data = data_q[1];
  assign bus.out2_data = data_q[2];
  assign bus.out3_data = data_q[3];
  assign bus.count0 = cnt_q[0];
  assign bus.count1 = cnt_q[1];
  assign bus.count2 = cnt_q[2];
  assign bus.count3 = cnt_q[3];
endmodule

// File: tb/tb_stream_demultiplexer.sv
// tb_stream_demultiplexer: scenario tasks plus a queue scoreboard for stream_demultiplexer
module tb_stream_demultiplexer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passed = 0;
  logic [3:0] mv = '0;
  logic [7:0] mcnt [4] = '{default: 8'd0};
  logic [7:0] q [4][$];
  stream_demultiplexer_if #(.WIDTH(8), .COUNT_WIDTH(8)) bus ();
  stream_demultiplexer #(.WIDTH(8), .COUNT_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] od(int k);
    return k == 0 ? bus.out0_data : k == 1 ? bus.out1_data : k == 2 ? bus.out2_data : bus.out3_data;
  endfunction
  function automatic logic [7:0] oc(int k);
    return k == 0 ? bus.count0 : k == 1 ? bus.count1 : k == 2 ? bus.count2 : bus.count3;
  endfunction
  always @(negedge clk) begin
    logic [1:0] s;
    logic er;
    logic [7:0] e;
    s = {bus.address1, bus.address0};
    er = !reset && (!mv[s] || bus.out_ready[s]);
    checks++;
    if (bus.in_ready !== er) $display("FAIL sb_in_ready t=%0t got %b want %b", $time, bus.in_ready, er);
    else passed++;
    checks++;
    if (bus.out_valid !== mv) $display("FAIL sb_out_valid t=%0t got %b want %b", $time, bus.out_valid, mv);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oc(k) !== mcnt[k]) $display("FAIL sb_count%0d t=%0t got %0d want %0d", k, $time, oc(k), mcnt[k]);
      else passed++;
    end
    for (int k = 0; k < 4; k++)
      if (reset) begin
        mv[k] = 1'b0;
        mcnt[k] = 8'd0;
        q[k].delete();
      end else begin
        if (mv[k] && bus.out_ready[k]) begin
          e = q[k].size() > 0 ? q[k].pop_front() : 8'hxx;
          checks++;
          if (od(k) !== e) $display("FAIL sb_drain%0d t=%0t got %h want %h", k, $time, od(k), e);
          else passed++;
          mv[k] = 1'b0;
        end
        if (bus.in_valid && er && s == 2'(k)) begin
          q[k].push_back(bus.in_data);
          mv[k] = 1'b1;
          mcnt[k] = mcnt[k] + 8'd1;
        end
      end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] a, input logic [7:0] d);
    bus.address1 = a[1];
    bus.address0 = a[0];
    bus.in_data = d;
    bus.in_valid = 1'b1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0000;
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 4'b0000;
    send(2'd2, 8'h5A);
    repeat (2) cyc();
    checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
    else passed++;
    checks++;
    if (bus.out_valid !== 4'b0000) $display("FAIL reset_out_valid got %b want 0000", bus.out_valid);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (od(k) !== 8'h00 || oc(k) !== 8'h00) $display("FAIL reset_ch%0d data %h count %0d want 0/0", k, od(k), oc(k));
      else passed++;
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    cyc();
  endtask
  task automatic test_routing();
    logic [7:0] w;
    bus.out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w = 8'(8'h11 * (i + 1));
      send(2'(i), w);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL route_ready%0d got %b want 1", i, bus.in_ready);
      else passed++;
      cyc();
      checks++;
      if (od(i) !== w || bus.out_valid[i] !== 1'b1) $display("FAIL route_out%0d got %h/%b want %h/1", i, od(i), bus.out_valid[i], w);
      else passed++;
    end
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 4'b1111) $display("FAIL route_all_valid got %b want 1111", bus.out_valid);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (oc(k) !== 8'd1) $display("FAIL route_count%0d got %0d want 1", k, oc(k));
      else passed++;
    end
    send(2'd1, 8'h55);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL route_fifth_ready got %b want 0", bus.in_ready);
    else passed++;
    cyc();
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b1111;
    cyc();
    bus.out_ready = 4'b0000;
  endtask
  task automatic test_backpressure();
    send(2'd2, 8'hAA);
    cyc();
    send(2'd0, 8'hBB);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_other_ready got %b want 1", bus.in_ready);
    else passed++;
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out0_data !== 8'hBB) $display("FAIL bp_out0 got %h want bb", bus.out0_data);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.out2_data !== 8'hAA || bus.out_valid[2] !== 1'b1) $display("FAIL bp_hold%0d got %h/%b want aa/1", i, bus.out2_data, bus.out_valid[2]);
      else passed++;
      cyc();
    end
    send(2'd2, 8'hCC);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL bp_stall%0d got %b want 0", i, bus.in_ready);
      else passed++;
      cyc();
    end
    bus.out_ready = 4'b0100;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", bus.in_ready);
    else passed++;
    cyc();
    bus.in_valid = 1'b0;
    bus.out_ready = 4'b0000;
    checks++;
    if (bus.out2_data !== 8'hCC || bus.out_valid[2] !== 1'b1) $display("FAIL bp_replace got %h/%b want cc/1", bus.out2_data, bus.out_valid[2]);
    else passed++;
    bus.out_ready = 4'b1111;
    cyc();
    bus.out_ready = 4'b0000;
  endtask
  task automatic test_back_to_back();
    do_reset();
    bus.out_ready = 4'b1000;
    for (int i = 1; i <= 8; i++) begin
      send(2'd3, 8'(i));
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, bus.in_ready);
      else passed++;
      cyc();
      checks++;
      if (bus.out3_data !== 8'(i) || bus.out_valid[3] !== 1'b1) $display("FAIL b2b_out%0d got %h/%b want %h/1", i, bus.out3_data, bus.out_valid[3], 8'(i));
      else passed++;
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.out_valid[3] !== 1'b0 || bus.count3 !== 8'd8) $display("FAIL b2b_end got %b/%0d want 0/8", bus.out_valid[3], bus.count3);
    else passed++;
    bus.out_ready = 4'b0000;
  endtask
  task automatic test_wrap();
    do_reset();
    send(2'd0, 8'h10);
    cyc();
    send(2'd3, 8'h30);
    cyc();
    bus.out_ready = 4'b0010;
    for (int i = 0; i < 256; i++) begin
      send(2'd1, 8'(i));
      cyc();
      if (i == 254) begin
        checks++;
        if (bus.count1 !== 8'd255) $display("FAIL wrap_255 got %0d want 255", bus.count1);
        else passed++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.count1 !== 8'd0) $display("FAIL wrap_zero got %0d want 0", bus.count1);
    else passed++;
    checks++;
    if (bus.count0 !== 8'd1 || bus.count2 !== 8'd0 || bus.count3 !== 8'd1) $display("FAIL wrap_others got %0d/%0d/%0d want 1/0/1", bus.count0, bus.count2, bus.count3);
    else passed++;
    checks++;
    if (bus.out0_data !== 8'h10 || bus.out3_data !== 8'h30) $display("FAIL wrap_held got %h/%h want 10/30", bus.out0_data, bus.out3_data);
    else passed++;
    cyc();
    bus.out_ready = 4'b0000;
  endtask
  task automatic test_reset_mid();
    do_reset();
    send(2'd0, 8'h50);
    cyc();
    send(2'd2, 8'h52);
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 4'b0101) $display("FAIL mid_pre got %b want 0101", bus.out_valid);
    else passed++;
    bus.out_ready = 4'b1111;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.out_ready = 4'b0000;
    checks++;
    if (bus.out_valid !== 4'b0000 || bus.count0 !== 8'd0 || bus.count2 !== 8'd0) $display("FAIL mid_clear got %b/%0d/%0d want 0000/0/0", bus.out_valid, bus.count0, bus.count2);
    else passed++;
    send(2'd2, 8'h77);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", bus.in_ready);
    else passed++;
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out2_data !== 8'h77 || bus.count2 !== 8'd1 || bus.out_valid !== 4'b0100) $display("FAIL mid_after got %h/%0d/%b want 77/1/0100", bus.out2_data, bus.count2, bus.out_valid);
    else passed++;
    cyc();
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.address0 = 1'b0;
    bus.address1 = 1'b0;
    bus.out_ready = 4'b0000;
    test_reset();
    test_routing();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/stream_demultiplexer.md
Name: stream_demultiplexer

Overview:
- 1-to-4 demultiplexer for a valid/ready data stream.
- Each input word is routed to one of four output channels, selected by the two address bits.
- Each output channel has a one-entry holding register, so output is registered and back-pressure is per channel.
- Sits downstream of a 4:1 selector and fans a shared bus out to four consumers.
- Keeps a wrapping count of words accepted per channel for debug and verification.

Parameters:
- WIDTH, 8: data width in bits of the input and of each output.
- COUNT_WIDTH, 8: width of each per-channel accept counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- address0  input  1  channel select, LSB.
- address1  input  1  channel select, MSB; selected channel sel = {address1, address0}.
- out_valid  output  4  bit k set = channel k holds a word.
- out_ready  input  4  bit k set = consumer k takes the word this cycle.
- out0_data  output  WIDTH  channel 0 word.
- out1_data  output  WIDTH  channel 1 word.
- out2_data  output  WIDTH  channel 2 word.
- out3_data  output  WIDTH  channel 3 word.
- count0  output  COUNT_WIDTH  words accepted into channel 0.
- count1  output  COUNT_WIDTH  words accepted into channel 1.
- count2  output  COUNT_WIDTH  words accepted into channel 2.
- count3  output  COUNT_WIDTH  words accepted into channel 3.

Behaviour:
- Clocking: single clock domain; reset is synchronous and active-high; all state updates on rising clk.
- Reset values: out_valid=4'b0000; outN_data=0; countN=0; in_ready=0 while reset is high.
- Reset mid-operation: buffered words are discarded, no output handshake completes that cycle, and counters clear.
- in_ready is combinational: in_ready = !reset && (!out_valid[sel] || out_ready[sel]).
  - It depends only on the selected channel; a full unselected channel never stalls the input.
- Accept: occurs when in_valid && in_ready at a rising edge.
  - The next state has outSEL_data = in_data, out_valid[sel] = 1, and count[sel] incremented by 1.
- Latency: a word accepted in cycle n appears on outSEL_data with out_valid[sel]=1 in cycle n+1.
- Drain: a channel k handshake occurs when out_valid[k] && out_ready[k] at an edge.
  - If channel k is not loaded in the same cycle, out_valid[k] clears next cycle.
- Simultaneous drain and load on the same channel: out_valid stays 1 and the new word replaces the old one.
  - Full throughput is one word per cycle into a continuously ready channel.
- Hold: while out_valid[k]=1 and out_ready[k]=0, outk_data and out_valid[k] stay stable.
- Upstream must keep in_data and the address stable while in_valid=1 and in_ready=0.
- in_valid=0: no state change except drains.
- out_ready for an empty channel is ignored.
- Counters wrap modulo 2^COUNT_WIDTH (255 -> 0 with defaults) and change only on accept.
- Channels other than sel are never written by an accept.
- Per-channel state is only out_valid[k] (EMPTY / FULL); there is no other state machine.
  - EMPTY -> FULL on accept to k.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on hold, or on drain with load.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, address=2, in_data=0x5A -> in_ready=0, out_valid=0000, all data=0, all counts=0; nothing is accepted.
- Routing: send 0x11, 0x22, 0x33, 0x44 to addresses 0, 1, 2, 3 with out_ready=0000.
  - Each word appears one cycle after its accept on the matching outN_data.
  - Final out_valid=1111, count0..3=1.
  - A fifth word to address 1 sees in_ready=0.
- Back-pressure isolation: fill channel 2 with 0xAA, keep out_ready[2]=0, then send 0xBB to address 0.
  - 0xBB is accepted; out2_data holds 0xAA, stable for 10 cycles.
  - A further word to address 2 is stalled until out_ready[2]=1.
- Streaming: 8 back-to-back words 0x01..0x08 to address 3 with out_ready[3]=1.
  - in_ready stays 1 and out3_data shows 0x01..0x08 on consecutive cycles, each one cycle late.
  - count3=8 and out_valid[3] clears one cycle after the last word.
- Counter wrap: accept 256 words into channel 1 -> count1 returns to 0; other counts are unchanged.
- Reset mid-stream: with out_valid=0101, assert reset for 1 cycle while out_ready=1111.
  - Next cycle out_valid=0000 and counts=0.
  - A word sent after reset deasserts is accepted normally.
